// File: rtl/filter_pkg.sv
// Shared definitions for the moving-average (boxcar) filter.
//   DATA_W_DEF    : default ADC sample width
//   LOG2_TAPS_DEF : default log2 of the tap count
//   state_t       : filter control state (FLUSH clears history, RUN accepts samples)
//   sum_width()   : running-sum width that can hold 2^log2_taps full-scale samples
package filter_pkg;

  localparam int DATA_W_DEF    = 14;
  localparam int LOG2_TAPS_DEF = 3;

  typedef enum logic {
    FLUSH = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Summing 2^k signed DATA_W values needs k extra bits; no overflow possible.
  function automatic int sum_width(input int data_w, input int log2_taps);
    return data_w + log2_taps;
  endfunction

endpackage

// File: rtl/edge_detector_1_bit.sv
// Registered rising-edge detector for a level signal in the local clock domain.
// Ports:
//   clk   : clock, posedge
//   rst   : asynchronous active-high reset
//   level : level input (e.g. AD_CONV, SPI_SCK)
//   rise  : one-cycle pulse, registered, one cycle after the 0->1 is seen
module edge_detector_1_bit (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic level_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d <= 1'b0;
      rise    <= 1'b0;
    end else begin
      level_d <= level;
      rise    <= level & ~level_d;
    end
  end

endmodule

// File: rtl/moving_average_filter.sv
// Boxcar low-pass FIR: average of the last 2^LOG2_TAPS signed samples, kept as a
// circular history buffer plus a running sum. One sample is taken per rising
// edge of strobe_in. After reset or clear_in the history is zeroed by a FLUSH
// pass of 2^LOG2_TAPS cycles, during which samples are ignored.
// Ports:
//   clk_in    : system clock, posedge
//   reset     : asynchronous active-high reset
//   strobe_in : sample strobe level
//   sample_in : signed sample, held stable around the strobe
//   clear_in  : synchronous flush request
//   avg_out   : signed floor(sum / 2^LOG2_TAPS)
//   avg_valid : one-cycle pulse when avg_out updates
//   primed    : 2^LOG2_TAPS samples accepted since the last flush
//   busy      : flushing; samples are dropped
module moving_average_filter
  import filter_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int LOG2_TAPS = LOG2_TAPS_DEF
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic                     strobe_in,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     clear_in,
  output logic signed [DATA_W-1:0] avg_out,
  output logic                     avg_valid,
  output logic                     primed,
  output logic                     busy
);

  localparam int TAPS  = 1 << LOG2_TAPS;
  localparam int SUM_W = sum_width(DATA_W, LOG2_TAPS);
  localparam logic [LOG2_TAPS:0] FILL_LAST = (LOG2_TAPS+1)'(TAPS - 1);

  state_t                   state;
  logic [LOG2_TAPS-1:0]     wr_ptr;
  logic [LOG2_TAPS:0]       fill_cnt;
  logic signed [SUM_W-1:0]  sum;
  logic signed [SUM_W-1:0]  sum_next;
  logic signed [SUM_W-1:0]  sample_x;
  logic signed [SUM_W-1:0]  oldest_x;
  logic signed [DATA_W-1:0] oldest;
  logic signed [DATA_W-1:0] hist [TAPS];
  logic                     rise;
  logic                     take;

  edge_detector_1_bit u_edge (
    .clk   (clk_in),
    .rst   (reset),
    .level (strobe_in),
    .rise  (rise)
  );

  // Clear has priority over a coincident sample.
  assign take   = (state == RUN) && rise && !clear_in;
  assign busy   = (state == FLUSH);

  // The slot about to be overwritten holds the sample leaving the window.
  assign oldest   = hist[wr_ptr];
  assign sample_x = {{LOG2_TAPS{sample_in[DATA_W-1]}}, sample_in};
  assign oldest_x = {{LOG2_TAPS{oldest[DATA_W-1]}}, oldest};
  assign sum_next = sum + sample_x - oldest_x;

  // History is not reset; FLUSH writes zeros into every slot instead.
  always_ff @(posedge clk_in) begin
    if (state == FLUSH)
      hist[wr_ptr] <= '0;
    else if (take)
      hist[wr_ptr] <= sample_in;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state     <= FLUSH;
      wr_ptr    <= '0;
      sum       <= '0;
      fill_cnt  <= '0;
      avg_out   <= '0;
      avg_valid <= 1'b0;
      primed    <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      case (state)
        FLUSH: begin
          sum      <= '0;
          fill_cnt <= '0;
          primed   <= 1'b0;
          if (clear_in) begin
            wr_ptr <= '0;
          end else begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == '1)
              state <= RUN;
          end
        end
        RUN: begin
          if (clear_in) begin
            state    <= FLUSH;
            wr_ptr   <= '0;
            sum      <= '0;
            fill_cnt <= '0;
            primed   <= 1'b0;
          end else if (take) begin
            sum       <= sum_next;
            wr_ptr    <= wr_ptr + 1'b1;
            // Upper DATA_W bits of the sum == arithmetic shift == floor division.
            avg_out   <= sum_next[SUM_W-1:LOG2_TAPS];
            avg_valid <= 1'b1;
            if (fill_cnt != FILL_LAST + 1'b1)
              fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == FILL_LAST)
              primed <= 1'b1;
          end
        end
        default: state <= FLUSH;
      endcase
    end
  end

endmodule
